stepper_sequencer: RTL
======================

Name: stepper_sequencer

Overview:
- Parametrised stepper-motor phase sequencer and the successor to the fixed 4-bit full-step phase counter.
- Generates 4-coil phase patterns in full-step or half-step mode, forward or reverse, at a programmable step rate.
- Runs a commanded number of steps per move, with start/busy/done handshake and abort.
- Sits between the motion-control logic and the coil driver pins.

Parameters:
- DIV_W, 16, width of step-rate divider; step period = div+1 clk cycles.
- CNT_W, 16, width of step count and position counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  move request; sampled only in IDLE
- nsteps  in  CNT_W  steps to execute; latched on accepted start
- dir  in  1  1 = forward (index +), 0 = reverse; latched on start
- half  in  1  1 = half-step, 0 = full-step; latched on start
- div  in  DIV_W  ticks per step minus 1; latched on start
- en  in  1  pause control; 0 freezes divider and stepping while RUN
- abort  in  1  terminate move immediately, no done pulse
- hold  in  1  1 = energise coils while idle, 0 = coils off when idle
- phase  out  4  coil drive pattern
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on move completion
- pos  out  CNT_W  signed position in half-step units, two's-complement wrap

Behaviour:
- Sequence table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. Full-step uses odd indices only: 0011, 0110, 1100, 1001.
- Reset (rst=0 at edge):
  - idx=1, state IDLE, busy=0, done=0, pos=0.
  - Divider and remaining counter are cleared.
  - Reset overrides all other inputs, including mid-move.
- Phase output (combinational from registers): phase = table[idx] when busy or hold, else 4'b0000.
- IDLE:
  - start=1 with nsteps!=0: latch inputs; load remaining=nsteps, divider=0; go to RUN. busy=1 from the next cycle.
  - start=1 with nsteps=0: done=1 for one cycle; stay IDLE; idx and pos unchanged.
- RUN:
  - Each cycle with en=1: if divider==div_l, perform a step and set divider=0; otherwise increment divider.
  - en=0 holds divider, idx and remaining.
  - The first step occurs on the (div_l+1)th enabled edge after entry. With div=0, one step per clock.
- Step rules:
  - Half-step: idx ±1 mod 8, pos ±1.
  - Full-step from odd idx: idx ±2 mod 8, pos ±2.
  - Full-step from even idx (left by a prior half-step move): idx ±1 to realign to odd, pos ±1.
- Completion:
  - Each step decrements remaining.
  - On the edge performing the step with remaining==1: go to IDLE, busy=0, done=1 for exactly one cycle.
  - phase shows the final pattern (or 0000 if hold=0) in that same cycle.
- Abort:
  - abort=1 in RUN: go to IDLE next edge, no step that edge, no done. idx and pos keep their last values.
  - abort in IDLE is ignored. abort has priority over a simultaneous step.
- Start while busy is ignored; the new request is not queued.
- idx wraps 7↔0 in both directions. pos wraps modulo 2^CNT_W.

Test Plan:
- Reset, hold=1 → phase=0011, busy=0, pos=0. Then full-step fwd, nsteps=4, div=0 → phase 0110, 1100, 1001, 0011 on consecutive cycles; done pulses with final 0011; pos=8.
- Half-step reverse, nsteps=3, div=2, from idx=1 → steps every 3 cycles: 0001, 1001, 1000; pos=-3 (0xFFFD); done single cycle.
- Half-step fwd 1 step (idx=2, 0010), then full-step fwd 2 steps → 0110 (realign, pos +1), then 1100 (pos +2).
- Full-step fwd nsteps=10, div=1, en low for 5 cycles mid-move → phase frozen during pause; total steps still 10; done once.
- abort on cycle 3 of an 8-step move → busy drops next edge, no done, phase/pos hold the last stepped value. start asserted while busy → ignored.
- start with nsteps=0 → done 1 cycle, busy stays 0. hold=0 in IDLE → phase=0000. rst low mid-move → idx=1, pos=0, busy=0 next edge.

Source files
------------

// File: rtl/stepper_sequencer_if.sv
// Motion-control side of the stepper sequencer: move command, pause/abort
// controls, coil pattern, status and position.
interface stepper_sequencer_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  // start is accepted only while busy=0; with nsteps!=0, busy rises on the
  // next edge and stays high until the move ends. done pulses for one cycle
  // on normal completion or on a zero-length request; abort ends a move
  // with no done pulse.
  logic             start;
  logic [CNT_W-1:0] nsteps;
  logic             dir;
  logic             half;
  logic [DIV_W-1:0] div;
  logic             en;
  logic             abort;
  logic             hold;
  logic [3:0]       phase;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pos;
  logic             state_dbg;

  modport master (
    output start, nsteps, dir, half, div, en, abort, hold,
    input  phase, busy, done, pos, state_dbg
  );

  modport slave (
    input  start, nsteps, dir, half, div, en, abort, hold,
    output phase, busy, done, pos, state_dbg
  );
endinterface

// File: rtl/stepper_sequencer.sv
// Stepper-motor phase sequencer: full/half-step, forward/reverse, programmable
// step period, counted moves with start/busy/done handshake and abort.
module stepper_sequencer #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    stepper_sequencer_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       idx;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_l;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] pos;
    logic             dir_l;
    logic             half_l;
    logic             done;

    logic [1:0]       stride;
    logic [2:0]       idx_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic [3:0]       pattern;

    // Full-step from an even index moves one slot so it lands back on odd.
    always_comb begin
        stride = (half_l || !idx[0]) ? 2'd1 : 2'd2;
        if (dir_l) begin
            idx_nxt = idx + {1'b0, stride};
            pos_nxt = pos + {{(CNT_W-2){1'b0}}, stride};
        end else begin
            idx_nxt = idx - {1'b0, stride};
            pos_nxt = pos - {{(CNT_W-2){1'b0}}, stride};
        end
    end

    always_comb begin
        case (idx)
            3'd0:    pattern = 4'b0001;
            3'd1:    pattern = 4'b0011;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b1100;
            3'd6:    pattern = 4'b1000;
            default: pattern = 4'b1001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 3'd1;
            div_cnt <= '0;
            div_l   <= '0;
            rem     <= '0;
            pos     <= '0;
            dir_l   <= 1'b0;
            half_l  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.nsteps != '0) begin
                            rem     <= bus.nsteps;
                            dir_l   <= bus.dir;
                            half_l  <= bus.half;
                            div_l   <= bus.div;
                            div_cnt <= '0;
                            state   <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.en) begin
                        if (div_cnt == div_l) begin
                            div_cnt <= '0;
                            idx     <= idx_nxt;
                            pos     <= pos_nxt;
                            rem     <= rem - {{(CNT_W-1){1'b0}}, 1'b1};
                            if (rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = done;
    assign bus.pos       = pos;
    assign bus.state_dbg = state;
    assign bus.phase     = ((state == RUN) || bus.hold) ? pattern : 4'b0000;

endmodule
